// File: rtl/d_pipeline_async_clear_if.sv
// Valid/ready bus for the elastic retiming pipeline.
// Producer side, consumer side and the occupancy count.
interface d_pipeline_async_clear_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    count;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output count
  );
endinterface

// File: rtl/d_pipeline_async_clear.sv
// Elastic register pipeline with bubble collapsing,
// stall, synchronous flush and asynchronous clear.
module d_pipeline_async_clear #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                      clk,
  input  logic                      clear_n,
  input  logic                      en,
  input  logic                      flush,
  d_pipeline_async_clear_if.slave   bus
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;

  logic [DEPTH-1:0] ready;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] src_data [DEPTH];
  logic             in_xfer;
  logic             out_xfer;

  // Ready ripples back from the consumer; an empty stage always accepts.
  always_comb begin
    logic r;
    ready = '0;
    r     = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      r        = !valid_q[i] | r;
      ready[i] = r;
    end
  end

  // Each stage's source: the producer for stage 0, else the stage before.
  always_comb begin
    src_valid    = '0;
    src_valid[0] = bus.in_valid;
    for (int i = 0; i < DEPTH; i++) begin
      src_data[i] = bus.in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      src_valid[i] = valid_q[i-1];
      src_data[i]  = data_q[i-1];
    end
  end

  assign bus.in_ready  = ready[0] & en & !flush;
  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.count     = count_q;

  assign in_xfer  = bus.in_valid & bus.in_ready;
  assign out_xfer = valid_q[DEPTH-1] & bus.out_ready & en & !flush;

  // Next state: flush wins, stall holds, otherwise advance ready stages.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (flush) begin
      valid_d = '0;
      count_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i] = RESET_VALUE;
      end
    end else if (en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ready[i]) begin
          valid_d[i] = src_valid[i];
          if (src_valid[i]) begin
            data_d[i] = src_data[i];
          end
        end
      end
      count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  // State registers; clear empties the pipeline at once.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= RESET_VALUE;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: doc/d_pipeline_async_clear.md
Name: d_pipeline_async_clear

Overview:
- Parametrised elastic register pipeline. Successor to the single-bit D flip-flop with asynchronous active-low clear.
- Generalises data width and stage count.
- Adds per-stage valid tracking, a valid/ready handshake with bubble collapsing, clock-enable stall, synchronous flush, and an occupancy count.
- Sits between producer and consumer blocks that need fixed-latency retiming with back-pressure.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 3, number of register stages (>=1)
- RESET_VALUE, 0, value loaded into every stage data register on clear or flush (WIDTH bits)

Ports:
- clk  input  1  rising-edge clock, single domain
- clear_n  input  1  asynchronous active-low clear; asserts immediately, deasserts synchronously to clk by the integrator
- en  input  1  clock enable; 0 freezes all state (stall)
- flush  input  1  synchronous flush, active-high
- in_valid  input  1  producer data valid
- in_data  input  WIDTH  producer data
- in_ready  output  1  pipeline can accept in_data this cycle
- out_valid  output  1  stage DEPTH-1 holds valid data
- out_data  output  WIDTH  stage DEPTH-1 data register
- out_ready  input  1  consumer accepts out_data
- count  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH

Behaviour:
- Reset: clear_n=0 forces the following regardless of clk/en/flush:
  - all stage data = RESET_VALUE
  - all stage valid = 0
  - count = 0
  - Outputs during clear: out_valid=0, out_data=RESET_VALUE, in_ready=1 (if en=1).
- Stage i (0..DEPTH-1) holds data_i and valid_i. Stage 0 is the input side; stage DEPTH-1 drives the outputs.
- Ready chain (combinational):
  - ready_DEPTH = out_ready
  - ready_i = !valid_i | ready_(i+1)
  - in_ready = ready_0 & en & !flush
- On posedge clk with en=1 and flush=0:
  - Each stage i with ready_i=1 loads from its predecessor: valid_i <= valid_(i-1); data_i <= data_(i-1) when valid_(i-1)=1, else data_i holds.
  - Stage 0's predecessor is in_valid/in_data.
  - A stage with ready_i=0 holds.
- Bubble collapsing: an empty stage always accepts, even when downstream is stalled. The pipeline fills to DEPTH entries under out_ready=0.
- Latency: an accepted word appears on out_valid exactly DEPTH cycles after acceptance when out_ready=1 throughout. Throughput is 1 word/cycle.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready & en & !flush.
- count update at each edge:
  - count <= count + input transfer - output transfer
  - simultaneous in/out transfer leaves count unchanged
  - must always equal popcount(valid)
- Full (count=DEPTH, out_ready=0): in_ready=0; in_data is ignored and not lost from the producer's view.
- Empty (count=0): out_valid=0; out_data holds its last value (RESET_VALUE after clear/flush).
- en=0: no state changes. in_ready=0; out_valid and out_data stay stable. The consumer must not count a transfer.
- flush=1 at an edge (en ignored):
  - all valid_i <= 0, data_i <= RESET_VALUE, count <= 0
  - in_ready=0 during flush; the input word is discarded
  - flush takes priority over all transfers
- clear_n asserted mid-stream: contents are lost immediately (asynchronous). First acceptance is possible at the first edge after clear_n returns to 1.
- Data is never reordered, duplicated or dropped, except by flush or clear.

Test Plan (WIDTH=8, DEPTH=3):
- Clear: clear_n=0 at t=3 (not on an edge) -> out_valid=0, out_data=0x00 and count=0 immediately. After release, in_ready=1.
- Streaming: out_ready=1, push 0x11,0x22,0x33,0x44 on consecutive cycles -> out_valid rises 3 cycles after the first accept, out_data shows 0x11..0x44 on consecutive cycles, count holds at 3 in steady state.
- Backpressure fill: out_ready=0, push 0xA1,0xA2,0xA3,0xA4 -> first three accepted, count=3, in_ready=0 holding 0xA4. Then out_ready=1 -> outputs 0xA1,0xA2,0xA3,0xA4 in order, none lost.
- Bubble collapse: push 0x01, idle 2 cycles, push 0x02 with out_ready=0 -> both compress toward the output, count=2, out_data=0x01.
- Stall and flush: with count=2, en=0 for 4 cycles -> no output change, count=2. Then flush=1 for one cycle with in_valid=1 -> count=0, out_valid=0, out_data=0x00, the input word is not accepted.
- Async clear mid-stream: clear_n=0 while count=3 -> out_valid=0 and count=0 immediately. After release, push 0x5A -> it appears 3 cycles later.
